sbox_arbiter: RTL and testbench
===============================

// Module: sbox_arbiter
// PURPOSE
//  Shares one registered sub_bytes stage (128-bit, 16 S-boxes) between two
//  requesters: the cipher round datapath (full 128-bit state) and key
//  expansion (32-bit SubWord). Arbitrates round-robin, muxes the operand into
//  sub_bytes and tracks in-flight owners with a tag pipeline. Routes each
//  result back to its owner with a one-cycle valid pulse. Sits between the
//  round controller / key scheduler and the single sub_bytes instance.
// PARAMETERS
//  SB_LATENCY  1   clock cycles from o_Sb_Data to i_Sb_Data (sub_bytes regs)
//  KEY_FIRST   1   1: RR pointer favours key after reset; 0: favours round
//  STAT_W      16  width of grant counters (SBOX_ARB_STATS_EN only)
// PORTS
//  clk          in   1    clock, all regs on posedge
//  rst_n        in   1    asynchronous active-low reset
//  i_Rnd_Req    in   1    round requester: operand valid, held until grant
//  i_Rnd_Data   in   128  round state operand
//  o_Rnd_Gnt    out  1    round operand accepted this cycle (combinational)
//  o_Rnd_Valid  out  1    round result valid (1-cycle pulse)
//  o_Rnd_Data   out  128  round result, held until next round result
//  i_Key_Req    in   1    key requester: operand valid, held until grant
//  i_Key_Word   in   32   key word operand
//  o_Key_Gnt    out  1    key operand accepted this cycle (combinational)
//  o_Key_Valid  out  1    key result valid (1-cycle pulse)
//  o_Key_Word   out  32   key result, held until next key result
//  o_Sb_Data    out  128  operand to sub_bytes (comb mux)
//  i_Sb_Data    in   128  result from sub_bytes
//  o_Busy       out  1    any tag in flight or result output pending
//  o_Rnd_Cnt    out  STAT_W round grants (SBOX_ARB_STATS_EN only)
//  o_Key_Cnt    out  STAT_W key grants (SBOX_ARB_STATS_EN only)
// BEHAVIOUR
//  - Reset: all registered outputs 0, tag pipe empty, ptr = KEY_FIRST.
//    Async assertion mid-operation drops in-flight tags; no valid follows.
//  - At most one grant per cycle; throughput 1 operand/cycle, no bubbles.
//  - Only one req high: grant it the same cycle. Both high: grant side
//    selected by ptr (1=key, 0=round). After any grant, ptr <= other side.
//    Both held continuously -> strict alternation.
//  - o_Sb_Data: round grant -> i_Rnd_Data; key grant -> {96'h0, i_Key_Word};
//    no grant -> 128'h0.
//  - Tag pipe SB_LATENCY deep, 2 bits {vld, is_key}, shifts every cycle;
//    entry written on grant, bubble otherwise.
//  - Pipe exit vld: owner's o_*_Data <= i_Sb_Data (key: bits [31:0]),
//    o_*_Valid <= 1 next cycle; other side's valid 0.
//  - Latency grant -> valid = SB_LATENCY+1 cycles. No backpressure:
//    owners must sample on the valid cycle.
//  - Gnt depends on req and ptr only, never on results (no comb loop).
//  - Req dropped before grant: no grant, no effect on ptr.
//  - o_Busy = OR of tag pipe vld bits and both valid regs.
// CONFIGURATION
//  SBOX_ARB_STATS_EN defined: o_Rnd_Cnt/o_Key_Cnt present; +1 per grant,
//    saturate at all-ones, cleared by reset.
//  Undefined: counter ports and logic absent; all other behaviour identical.
// TESTING
//  1 Reset held, random reqs -> all outputs 0, no gnt asserted.
//  2 Rnd req, data 128'h0 -> o_Rnd_Gnt cyc0, o_Rnd_Valid cyc2 with
//    o_Rnd_Data = {16{8'h63}}; o_Key_Valid stays 0.
//  3 Key req, 32'h00000001 -> o_Sb_Data = 128'h1, o_Key_Valid cyc2,
//    o_Key_Word = 32'h6363637c.
//  4 Both reqs held 6 cycles from reset, KEY_FIRST=1 -> gnts K,R,K,R,K,R;
//    valids follow same order 2 cycles later, back-to-back.
//  5 Rnd grant, rst_n low 1 cycle before result -> no o_Rnd_Valid ever;
//    next req after release completes normally.
//  6 STATS_EN, STAT_W=2: 5 rnd grants, 2 key grants -> o_Rnd_Cnt=3
//    (saturated), o_Key_Cnt=2.

Source files
------------

// File: rtl/sbox_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sbox_arbiter_if : requester and sub_bytes handshake bundle for sbox_arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
interface sbox_arbiter_if;
  logic         i_Rnd_Req;
  logic [127:0] i_Rnd_Data;
  logic         o_Rnd_Gnt;
  logic         o_Rnd_Valid;
  logic [127:0] o_Rnd_Data;
  logic         i_Key_Req;
  logic [31:0]  i_Key_Word;
  logic         o_Key_Gnt;
  logic         o_Key_Valid;
  logic [31:0]  o_Key_Word;
  logic [127:0] o_Sb_Data;
  logic [127:0] i_Sb_Data;

  modport slave (
    input  i_Rnd_Req, i_Rnd_Data, i_Key_Req, i_Key_Word, i_Sb_Data,
    output o_Rnd_Gnt, o_Rnd_Valid, o_Rnd_Data,
    output o_Key_Gnt, o_Key_Valid, o_Key_Word, o_Sb_Data
  );

  modport master (
    output i_Rnd_Req, i_Rnd_Data, i_Key_Req, i_Key_Word, i_Sb_Data,
    input  o_Rnd_Gnt, o_Rnd_Valid, o_Rnd_Data,
    input  o_Key_Gnt, o_Key_Valid, o_Key_Word, o_Sb_Data
  );
endinterface
`default_nettype wire

// File: rtl/sbox_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sbox_arbiter : round-robin share of one sub_bytes stage between the round
// datapath and key expansion. Optional: SBOX_ARB_STATS_EN (grant counters).
// Rev 1.0
// ----------------------------------------------------------------------------
module sbox_arbiter #(
  parameter int SB_LATENCY = 1,
  parameter bit KEY_FIRST  = 1'b1
`ifdef SBOX_ARB_STATS_EN
  ,
  parameter int STAT_W     = 16
`endif
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  sbox_arbiter_if.slave     bus,
  output logic              o_Busy
`ifdef SBOX_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] o_Rnd_Cnt,
  output logic [STAT_W-1:0] o_Key_Cnt
`endif
);

  logic                  ptr_q, ptr_d;
  logic [SB_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [SB_LATENCY-1:0] tag_key_q, tag_key_d;
  logic                  rnd_valid_q, rnd_valid_d;
  logic                  key_valid_q, key_valid_d;
  logic [127:0]          rnd_data_q, rnd_data_d;
  logic [31:0]           key_word_q, key_word_d;
  logic                  rnd_gnt, key_gnt;
  logic [127:0]          sb_data;

  // ptr_q = 1 favours key; the side just granted loses priority next time
  always_comb begin
    key_gnt = bus.i_Key_Req & (~bus.i_Rnd_Req | ptr_q);
    rnd_gnt = bus.i_Rnd_Req & ~key_gnt;
    ptr_d   = ptr_q;
    if (rnd_gnt)
      ptr_d = 1'b1;
    else if (key_gnt)
      ptr_d = 1'b0;
    sb_data = '0;
    if (rnd_gnt)
      sb_data = bus.i_Rnd_Data;
    else if (key_gnt)
      sb_data = {96'h0, bus.i_Key_Word};
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_key_d    = '0;
    tag_vld_d[0] = rnd_gnt | key_gnt;
    tag_key_d[0] = key_gnt;
    for (int i = 1; i < SB_LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_key_d[i] = tag_key_q[i-1];
    end
    rnd_valid_d = tag_vld_q[SB_LATENCY-1] & ~tag_key_q[SB_LATENCY-1];
    key_valid_d = tag_vld_q[SB_LATENCY-1] &  tag_key_q[SB_LATENCY-1];
    rnd_data_d  = rnd_valid_d ? bus.i_Sb_Data       : rnd_data_q;
    key_word_d  = key_valid_d ? bus.i_Sb_Data[31:0] : key_word_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= KEY_FIRST;
      tag_vld_q   <= '0;
      tag_key_q   <= '0;
      rnd_valid_q <= 1'b0;
      key_valid_q <= 1'b0;
      rnd_data_q  <= '0;
      key_word_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      tag_vld_q   <= tag_vld_d;
      tag_key_q   <= tag_key_d;
      rnd_valid_q <= rnd_valid_d;
      key_valid_q <= key_valid_d;
      rnd_data_q  <= rnd_data_d;
      key_word_q  <= key_word_d;
    end
  end

  // Grants are masked only at the outputs so rst_n never feeds a flop D input
  assign bus.o_Rnd_Gnt   = rnd_gnt & rst_n;
  assign bus.o_Key_Gnt   = key_gnt & rst_n;
  assign bus.o_Sb_Data   = sb_data & {128{rst_n}};
  assign bus.o_Rnd_Valid = rnd_valid_q;
  assign bus.o_Rnd_Data  = rnd_data_q;
  assign bus.o_Key_Valid = key_valid_q;
  assign bus.o_Key_Word  = key_word_q;
  assign o_Busy          = (|tag_vld_q) | rnd_valid_q | key_valid_q;

`ifdef SBOX_ARB_STATS_EN
  logic [STAT_W-1:0] rnd_cnt_q, rnd_cnt_d;
  logic [STAT_W-1:0] key_cnt_q, key_cnt_d;

  always_comb begin
    rnd_cnt_d = rnd_cnt_q;
    key_cnt_d = key_cnt_q;
    if (rnd_gnt && !(&rnd_cnt_q))
      rnd_cnt_d = rnd_cnt_q + 1'b1;
    if (key_gnt && !(&key_cnt_q))
      key_cnt_d = key_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_cnt_q <= '0;
      key_cnt_q <= '0;
    end else begin
      rnd_cnt_q <= rnd_cnt_d;
      key_cnt_q <= key_cnt_d;
    end
  end

  assign o_Rnd_Cnt = rnd_cnt_q;
  assign o_Key_Cnt = key_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sbox_arbiter.sv
`default_nettype none
// tb_sbox_arbiter: directed + randomized bench; an AES S-box model stands in
// for sub_bytes and a queue-based reference predicts grants and results.
module tb_sbox_arbiter;
  localparam int SB_LAT    = 1;
  localparam bit KEY_FIRST = 1'b1;
`ifdef SBOX_ARB_STATS_EN
  localparam int STAT_W    = 2;
  logic [STAT_W-1:0] rnd_cnt, key_cnt;
  logic [STAT_W-1:0] m_rc, m_kc;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         busy;
  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] sb_out = '0;

  sbox_arbiter_if bus();

  sbox_arbiter #(
    .SB_LATENCY (SB_LAT),
    .KEY_FIRST  (KEY_FIRST)
`ifdef SBOX_ARB_STATS_EN
    ,
    .STAT_W     (STAT_W)
`endif
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .o_Busy (busy)
`ifdef SBOX_ARB_STATS_EN
    ,
    .o_Rnd_Cnt (rnd_cnt),
    .o_Key_Cnt (key_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 followed by the AES affine transform
  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub128(input logic [127:0] x);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = sbox_t[x[i*8 +: 8]];
    return r;
  endfunction

  always @(posedge clk) sb_out <= sub128(bus.o_Sb_Data);
  assign bus.i_Sb_Data = sb_out;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int           due;
    bit           is_key;
    logic [127:0] res;
  } ent_t;

  ent_t         q[$];
  ent_t         e_pop;
  bit           m_ptr, mg_r, mg_k, ev_r, ev_k, eb;
  logic [127:0] m_rd, esb;
  logic [31:0]  m_kw;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_ptr = KEY_FIRST; m_rd = '0; m_kw = '0; mg_r = 1'b0; mg_k = 1'b0;
      chk("rst_rnd_gnt",   bus.o_Rnd_Gnt,   0);
      chk("rst_key_gnt",   bus.o_Key_Gnt,   0);
      chk("rst_rnd_valid", bus.o_Rnd_Valid, 0);
      chk("rst_key_valid", bus.o_Key_Valid, 0);
      chk("rst_rnd_data",  bus.o_Rnd_Data,  0);
      chk("rst_key_word",  bus.o_Key_Word,  0);
      chk("rst_sb_data",   bus.o_Sb_Data,   0);
      chk("rst_busy",      busy,            0);
`ifdef SBOX_ARB_STATS_EN
      m_rc = '0; m_kc = '0;
      chk("rst_rnd_cnt", rnd_cnt, 0);
      chk("rst_key_cnt", key_cnt, 0);
`endif
    end else begin
      mg_r = 1'b0; mg_k = 1'b0;
      if (bus.i_Rnd_Req && bus.i_Key_Req) begin
        if (m_ptr) mg_k = 1'b1; else mg_r = 1'b1;
      end else begin
        mg_r = bus.i_Rnd_Req;
        mg_k = bus.i_Key_Req;
      end
      esb = mg_r ? bus.i_Rnd_Data : (mg_k ? {96'h0, bus.i_Key_Word} : 128'h0);
      eb  = (q.size() != 0);
      ev_r = 1'b0; ev_k = 1'b0;
      while (q.size() != 0 && q[0].due == cyc) begin
        e_pop = q.pop_front();
        if (e_pop.is_key) begin ev_k = 1'b1; m_kw = e_pop.res[31:0]; end
        else              begin ev_r = 1'b1; m_rd = e_pop.res;       end
      end
      chk("rnd_gnt",   bus.o_Rnd_Gnt,   mg_r);
      chk("key_gnt",   bus.o_Key_Gnt,   mg_k);
      chk("sb_data",   bus.o_Sb_Data,   esb);
      chk("rnd_valid", bus.o_Rnd_Valid, ev_r);
      chk("key_valid", bus.o_Key_Valid, ev_k);
      chk("rnd_data",  bus.o_Rnd_Data,  m_rd);
      chk("key_word",  bus.o_Key_Word,  m_kw);
      chk("busy",      busy,            eb);
`ifdef SBOX_ARB_STATS_EN
      chk("rnd_cnt", rnd_cnt, m_rc);
      chk("key_cnt", key_cnt, m_kc);
      if (mg_r && m_rc != {STAT_W{1'b1}}) m_rc = m_rc + 1'b1;
      if (mg_k && m_kc != {STAT_W{1'b1}}) m_kc = m_kc + 1'b1;
`endif
      if (mg_r || mg_k) q.push_back('{cyc + SB_LAT + 1, mg_k, sub128(esb)});
      if (mg_r)      m_ptr = 1'b1;
      else if (mg_k) m_ptr = 1'b0;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; bus.i_Rnd_Req = 1'b0; bus.i_Key_Req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) sbox_t[a] = sbox_calc(a[7:0]);
    chk("model_sbox_00", sbox_t[8'h00], 8'h63);
    chk("model_sbox_01", sbox_t[8'h01], 8'h7c);
    chk("model_sbox_53", sbox_t[8'h53], 8'hed);

    bus.i_Rnd_Req = 1'b0; bus.i_Rnd_Data = '0;
    bus.i_Key_Req = 1'b0; bus.i_Key_Word = '0;

    // Reset held with random requests
    repeat (4) begin
      @(posedge clk); #1;
      bus.i_Rnd_Req  = 1'($urandom_range(0, 1));
      bus.i_Key_Req  = 1'($urandom_range(0, 1));
      bus.i_Rnd_Data = {$urandom, $urandom, $urandom, $urandom};
      bus.i_Key_Word = $urandom;
      @(negedge clk);
      chk("t1_rnd_gnt", bus.o_Rnd_Gnt, 0);
      chk("t1_key_gnt", bus.o_Key_Gnt, 0);
    end
    @(posedge clk); #1;
    bus.i_Rnd_Req = 1'b0; bus.i_Key_Req = 1'b0; rst_n = 1'b1;

    // Single round request with all-zero state
    bus.i_Rnd_Req = 1'b1; bus.i_Rnd_Data = '0;
    @(negedge clk);
    chk("t2_gnt", bus.o_Rnd_Gnt, 1);
    @(posedge clk); #1; bus.i_Rnd_Req = 1'b0;
    @(negedge clk);
    chk("t2_valid_early", bus.o_Rnd_Valid, 0);
    @(negedge clk);
    chk("t2_valid", bus.o_Rnd_Valid, 1);
    chk("t2_data",  bus.o_Rnd_Data, {16{8'h63}});
    chk("t2_kvalid", bus.o_Key_Valid, 0);

    // Single key request
    @(posedge clk); #1;
    bus.i_Key_Req = 1'b1; bus.i_Key_Word = 32'h00000001;
    @(negedge clk);
    chk("t3_sb", bus.o_Sb_Data, 128'h1);
    chk("t3_gnt", bus.o_Key_Gnt, 1);
    @(posedge clk); #1; bus.i_Key_Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t3_valid", bus.o_Key_Valid, 1);
    chk("t3_word",  bus.o_Key_Word, 32'h6363637c);

    // Both held from reset: strict alternation starting with key
    do_reset();
    bus.i_Rnd_Data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_Key_Word = $urandom;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      bus.i_Rnd_Req = (i < 6);
      bus.i_Key_Req = (i < 6);
      @(negedge clk);
      chk("t4_key_gnt",   bus.o_Key_Gnt,   (i < 6) && (i % 2 == 0));
      chk("t4_rnd_gnt",   bus.o_Rnd_Gnt,   (i < 6) && (i % 2 == 1));
      chk("t4_key_valid", bus.o_Key_Valid, (i >= 2) && (i % 2 == 0));
      chk("t4_rnd_valid", bus.o_Rnd_Valid, (i >= 3) && (i % 2 == 1));
    end
    @(posedge clk); #1; bus.i_Rnd_Req = 1'b0; bus.i_Key_Req = 1'b0;

    // Async reset while a round result is in flight
    do_reset();
    bus.i_Rnd_Req = 1'b1; bus.i_Rnd_Data = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    chk("t5_gnt", bus.o_Rnd_Gnt, 1);
    @(posedge clk); #1; bus.i_Rnd_Req = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_valid", bus.o_Rnd_Valid, 0);
    end
    @(posedge clk); #1;
    bus.i_Rnd_Req = 1'b1; bus.i_Rnd_Data = 128'h1;
    @(negedge clk);
    chk("t5_gnt2", bus.o_Rnd_Gnt, 1);
    @(posedge clk); #1; bus.i_Rnd_Req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid2", bus.o_Rnd_Valid, 1);
    chk("t5_data2",  bus.o_Rnd_Data, {{15{8'h63}}, 8'h7c});

    // Randomized traffic with occasional abandoned requests and resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (bus.i_Rnd_Req && (mg_r || $urandom_range(0, 19) == 0)) bus.i_Rnd_Req = 1'b0;
      if (!bus.i_Rnd_Req && $urandom_range(0, 3) != 0) begin
        bus.i_Rnd_Req  = 1'b1;
        bus.i_Rnd_Data = {$urandom, $urandom, $urandom, $urandom};
      end
      if (bus.i_Key_Req && (mg_k || $urandom_range(0, 19) == 0)) bus.i_Key_Req = 1'b0;
      if (!bus.i_Key_Req && $urandom_range(0, 2) != 0) begin
        bus.i_Key_Req  = 1'b1;
        bus.i_Key_Word = $urandom;
      end
      if (n % 700 == 350) begin
        #2 rst_n = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
      end
    end
    @(posedge clk); #1; bus.i_Rnd_Req = 1'b0; bus.i_Key_Req = 1'b0;
    repeat (4) @(posedge clk);

`ifdef SBOX_ARB_STATS_EN
    // Counter saturation at STAT_W = 2
    do_reset();
    bus.i_Rnd_Req = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    bus.i_Rnd_Req = 1'b0; bus.i_Key_Req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    bus.i_Key_Req = 1'b0;
    @(negedge clk);
    chk("t6_rnd_cnt", rnd_cnt, 2'd3);
    chk("t6_key_cnt", key_cnt, 2'd2);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
